// File: rtl/cfs_rx_ctrl.sv
// RX-side MD controller: checks each transfer's offset/size, pushes legal ones to the RX FIFO,
// drops illegal ones and counts them. Error responses are enabled by `define CFS_RX_CTRL_ERR_RESP_EN.
module cfs_rx_ctrl #(
  parameter  int ALGN_DATA_WIDTH       = 32,
  parameter  int STATUS_CNT_DROP_WIDTH = 8,
  localparam int BYTES                 = ALGN_DATA_WIDTH / 8,
  localparam int OFFSET_WIDTH          = (BYTES <= 1) ? 1 : $clog2(BYTES),
  localparam int SIZE_WIDTH            = $clog2(BYTES) + 1
) (
  input  logic                             pclk,
  input  logic                             presetn,
  input  logic                             md_rx_valid,
  input  logic [ALGN_DATA_WIDTH-1:0]       md_rx_data,
  input  logic [OFFSET_WIDTH-1:0]          md_rx_offset,
  input  logic [SIZE_WIDTH-1:0]            md_rx_size,
  output logic                             md_rx_ready,
  output logic                             md_rx_err,
  output logic                             push_valid,
  output logic [ALGN_DATA_WIDTH-1:0]       push_data,
  output logic [OFFSET_WIDTH-1:0]          push_offset,
  output logic [SIZE_WIDTH-1:0]            push_size,
  input  logic                             push_ready,
  input  logic                             ctrl_clr,
  output logic [STATUS_CNT_DROP_WIDTH-1:0] status_cnt_drop,
  output logic                             max_drop
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] PUSH = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

`ifdef CFS_RX_CTRL_ERR_RESP_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  localparam logic [SIZE_WIDTH:0] BYTES_W = (SIZE_WIDTH + 1)'(BYTES);

  // Sums are widened by one bit so offset+size and BYTES+offset never wrap.
  function automatic logic is_legal(input logic [OFFSET_WIDTH-1:0] off,
                                    input logic [SIZE_WIDTH-1:0]   sz);
    logic [SIZE_WIDTH:0] off_w;
    logic [SIZE_WIDTH:0] sz_w;
    off_w = (SIZE_WIDTH + 1)'(off);
    sz_w  = (SIZE_WIDTH + 1)'(sz);
    if (sz_w == '0) return 1'b0;
    return ((off_w + sz_w) <= BYTES_W) && (((BYTES_W + off_w) % sz_w) == '0);
  endfunction

  logic [1:0]                       state_q, state_d;
  logic                             ready_q, ready_d;
  logic                             err_q, err_d;
  logic                             pvld_q, pvld_d;
  logic [ALGN_DATA_WIDTH-1:0]       pdata_q, pdata_d;
  logic [OFFSET_WIDTH-1:0]          poff_q, poff_d;
  logic [SIZE_WIDTH-1:0]            psize_q, psize_d;
  logic [STATUS_CNT_DROP_WIDTH-1:0] cnt_q, cnt_d;
  logic                             drop;

  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    err_d   = err_q;
    pvld_d  = pvld_q;
    pdata_d = pdata_q;
    poff_d  = poff_q;
    psize_d = psize_q;
    drop    = 1'b0;
    case (state_q)
      IDLE: begin
        if (md_rx_valid) begin
          if (is_legal(md_rx_offset, md_rx_size)) begin
            pvld_d  = 1'b1;
            pdata_d = md_rx_data;
            poff_d  = md_rx_offset;
            psize_d = md_rx_size;
            state_d = PUSH;
          end else begin
            err_d   = ERR_EN;
            drop    = 1'b1;
            state_d = RESP;
          end
        end
      end
      PUSH: begin
        if (pvld_q && push_ready) begin
          pvld_d  = 1'b0;
          err_d   = 1'b0;
          ready_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        // A drop enters RESP with ready low, so it raises ready one cycle later
        // to match the push path latency.
        if (ready_q) begin
          ready_d = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end else begin
          ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear has priority over a drop landing on the same edge.
  always_comb begin
    cnt_d = cnt_q;
    if (ctrl_clr) cnt_d = '0;
    else if (drop && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      pvld_q  <= 1'b0;
      pdata_q <= '0;
      poff_q  <= '0;
      psize_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      pvld_q  <= pvld_d;
      pdata_q <= pdata_d;
      poff_q  <= poff_d;
      psize_q <= psize_d;
      cnt_q   <= cnt_d;
    end
  end

  assign md_rx_ready     = ready_q;
  assign md_rx_err       = err_q;
  assign push_valid      = pvld_q;
  assign push_data       = pdata_q;
  assign push_offset     = poff_q;
  assign push_size       = psize_q;
  assign status_cnt_drop = cnt_q;
  assign max_drop        = &cnt_q;

endmodule

// File: tb/tb_cfs_rx_ctrl.sv
// Bench for cfs_rx_ctrl (32-bit data, 8-bit drop counter) with a transfer-level reference model.
module tb_cfs_rx_ctrl;
  localparam int DW = 32;
  localparam int CW = 8;
  localparam int BYTES = 4;
  localparam int OW = 2;
  localparam int SW = 3;
  localparam int CNT_MAX = 255;

  logic          pclk = 1'b0;
  logic          presetn;
  logic          md_rx_valid;
  logic [DW-1:0] md_rx_data;
  logic [OW-1:0] md_rx_offset;
  logic [SW-1:0] md_rx_size;
  logic          md_rx_ready;
  logic          md_rx_err;
  logic          push_valid;
  logic [DW-1:0] push_data;
  logic [OW-1:0] push_offset;
  logic [SW-1:0] push_size;
  logic          push_ready;
  logic          ctrl_clr;
  logic [CW-1:0] status_cnt_drop;
  logic          max_drop;

  cfs_rx_ctrl #(.ALGN_DATA_WIDTH(DW), .STATUS_CNT_DROP_WIDTH(CW)) dut (
    .pclk(pclk), .presetn(presetn),
    .md_rx_valid(md_rx_valid), .md_rx_data(md_rx_data),
    .md_rx_offset(md_rx_offset), .md_rx_size(md_rx_size),
    .md_rx_ready(md_rx_ready), .md_rx_err(md_rx_err),
    .push_valid(push_valid), .push_data(push_data),
    .push_offset(push_offset), .push_size(push_size), .push_ready(push_ready),
    .ctrl_clr(ctrl_clr), .status_cnt_drop(status_cnt_drop), .max_drop(max_drop)
  );

  always #5 pclk = ~pclk;

  int n_assert = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;
`ifdef CFS_RX_CTRL_ERR_RESP_EN
  localparam logic EXP_ERR_ON_DROP = 1'b1;
`else
  localparam logic EXP_ERR_ON_DROP = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_legal(input int off, input int sz);
    if (sz == 0) return 1'b0;
    return (off + sz <= BYTES) && (((BYTES + off) % sz) == 0);
  endfunction

  task automatic chk_cnt();
    chk("cnt_drop", 32'(status_cnt_drop), 32'(exp_cnt));
    chk("max_drop", 32'(max_drop), 32'(exp_cnt == CNT_MAX));
  endtask

  // Starts at a falling edge with the DUT idle; returns at a falling edge with the DUT idle.
  task automatic xfer(input int off, input int sz, input logic [DW-1:0] data,
                      input int stall, input bit clr);
    bit legal;
    logic [OW-1:0] o;
    logic [SW-1:0] s;
    legal = model_legal(off, sz);
    o = off[OW-1:0];
    s = sz[SW-1:0];
    md_rx_valid  = 1'b1;
    md_rx_offset = o;
    md_rx_size   = s;
    md_rx_data   = data;
    push_ready   = (stall == 0) ? 1'b1 : 1'b0;
    ctrl_clr     = clr;
    if (clr) exp_cnt = 0;
    else if (!legal && exp_cnt < CNT_MAX) exp_cnt++;
    @(posedge pclk); @(negedge pclk);
    ctrl_clr = 1'b0;
    chk_cnt();
    chk("ready_c1", 32'(md_rx_ready), 32'd0);
    if (legal) begin
      chk("push_valid_c1", 32'(push_valid), 32'd1);
      chk("push_data", push_data, data);
      chk("push_offset", 32'(push_offset), 32'(off));
      chk("push_size", 32'(push_size), 32'(sz));
      for (int k = 0; k < stall; k++) begin
        @(posedge pclk); @(negedge pclk);
        chk("stall_push_valid", 32'(push_valid), 32'd1);
        chk("stall_push_data", push_data, data);
        chk("stall_ready", 32'(md_rx_ready), 32'd0);
      end
      push_ready = 1'b1;
      @(posedge pclk); @(negedge pclk);
      chk("ready_push", 32'(md_rx_ready), 32'd1);
      chk("err_push", 32'(md_rx_err), 32'd0);
      chk("push_valid_done", 32'(push_valid), 32'd0);
    end else begin
      chk("push_valid_drop", 32'(push_valid), 32'd0);
      @(posedge pclk); @(negedge pclk);
      chk("ready_drop", 32'(md_rx_ready), 32'd1);
      chk("err_drop", 32'(md_rx_err), 32'(EXP_ERR_ON_DROP));
      chk("push_valid_drop2", 32'(push_valid), 32'd0);
    end
    md_rx_valid = 1'b0;
    @(posedge pclk); @(negedge pclk);
    chk("ready_end", 32'(md_rx_ready), 32'd0);
    chk("err_end", 32'(md_rx_err), 32'd0);
  endtask

  task automatic clear_cnt();
    ctrl_clr = 1'b1;
    @(posedge pclk); @(negedge pclk);
    ctrl_clr = 1'b0;
    exp_cnt = 0;
    chk_cnt();
  endtask

  initial begin
    presetn      = 1'b0;
    md_rx_valid  = 1'b0;
    md_rx_data   = '0;
    md_rx_offset = '0;
    md_rx_size   = '0;
    push_ready   = 1'b1;
    ctrl_clr     = 1'b0;
    repeat (2) @(negedge pclk);
    chk("rst_ready", 32'(md_rx_ready), 32'd0);
    chk("rst_err", 32'(md_rx_err), 32'd0);
    chk("rst_push_valid", 32'(push_valid), 32'd0);
    chk("rst_push_data", push_data, 32'd0);
    chk("rst_push_offset", 32'(push_offset), 32'd0);
    chk("rst_push_size", 32'(push_size), 32'd0);
    chk_cnt();
    presetn = 1'b1;
    @(negedge pclk);

    // Directed: full-word push, misaligned drop, long stall, other aligned cases.
    xfer(0, 4, 32'hDEADBEEF, 0, 1'b0);
    xfer(1, 2, 32'h12345678, 0, 1'b0);
    xfer(0, 4, 32'hA5A5_0F0F, 10, 1'b0);
    xfer(2, 2, 32'h0000_BEEF, 0, 1'b0);
    xfer(3, 1, 32'h0000_00AA, 1, 1'b0);
    xfer(0, 0, 32'h1111_1111, 0, 1'b0);
    xfer(1, 3, 32'h2222_2222, 0, 1'b0);
    xfer(3, 2, 32'h3333_3333, 0, 1'b0);

    // Saturation: 256 drops from zero, then one more.
    clear_cnt();
    for (int i = 0; i < 257; i++) xfer(1, 2, $urandom, 0, 1'b0);

    // Clear landing together with a drop at count 5.
    clear_cnt();
    for (int i = 0; i < 5; i++) xfer(0, 3, $urandom, 0, 1'b0);
    chk("cnt_is_5", 32'(status_cnt_drop), 32'd5);
    xfer(2, 4, $urandom, 0, 1'b1);

    // Reset while waiting in PUSH.
    xfer(0, 5, $urandom, 0, 1'b0);
    md_rx_valid  = 1'b1;
    md_rx_offset = 2'd0;
    md_rx_size   = 3'd4;
    md_rx_data   = 32'hCAFE_F00D;
    push_ready   = 1'b0;
    @(posedge pclk); @(negedge pclk);
    chk("pre_rst_push_valid", 32'(push_valid), 32'd1);
    presetn = 1'b0;
    #1;
    exp_cnt = 0;
    chk("mid_rst_push_valid", 32'(push_valid), 32'd0);
    chk("mid_rst_ready", 32'(md_rx_ready), 32'd0);
    chk_cnt();
    md_rx_valid = 1'b0;
    push_ready  = 1'b1;
    @(negedge pclk);
    presetn = 1'b1;
    @(negedge pclk);
    chk("post_rst_ready", 32'(md_rx_ready), 32'd0);
    xfer(1, 1, 32'h5555_AAAA, 2, 1'b0);

    // Random transfers against the model.
    for (int i = 0; i < 60; i++)
      xfer(int'($urandom_range(3, 0)), int'($urandom_range(7, 0)), $urandom,
           int'($urandom_range(3, 0)), ($urandom_range(9, 0) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
